mcr_rom_port_arbiter: RTL and testbench

//  Shares one single-port synchronous program ROM between the main Z80 (cpu) and the sound Z80 (snd).

---
 rtl/mcr_rom_pkg.sv | 25 ++
 rtl/mcr_rom_port_arbiter_rr_arb2.sv | 45 ++++
 rtl/mcr_rom_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mcr_rom_port_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcr_rom_pkg.sv
// Shared types and ROM map for the MCR program ROM port arbiter.
package mcr_rom_pkg;

  localparam int ROM_AW = 16;
  localparam int ROM_DW = 8;

  // Program store map: main CPU owns the low 48k, sound CPU the top 16k
  localparam logic [15:0] CPU_ROM_BASE = 16'h0000;
  localparam logic [15:0] CPU_ROM_LAST = 16'hBFFF;
  localparam logic [15:0] SND_ROM_BASE = 16'hC000;
  localparam logic [15:0] SND_ROM_LAST = 16'hFFFF;
  localparam logic [15:0] SND_BASE     = SND_ROM_BASE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DL   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_SND = 1'b1
  } grant_e;

endpackage

// File: rtl/mcr_rom_port_arbiter_rr_arb2.sv
// Two-way round-robin picker; a requester is masked while its ack is high.
module rr_arb2
  import mcr_rom_pkg::*;
(
  input  logic clk_sys,
  input  logic rst_n,
  input  logic req_cpu,
  input  logic req_snd,
  input  logic mask_cpu,
  input  logic mask_snd,
  input  logic commit,
  output logic gnt_valid,
  output logic gnt_snd
);

  grant_e last_grant;
  grant_e pick;
  logic   elig_cpu;
  logic   elig_snd;

  assign elig_cpu = req_cpu && !mask_cpu;
  assign elig_snd = req_snd && !mask_snd;

  // On a tie the requester that did not win last time goes first
  always_comb begin
    pick = GNT_SND;
    if (elig_cpu && elig_snd) begin
      pick = (last_grant == GNT_CPU) ? GNT_SND : GNT_CPU;
    end else if (elig_cpu) begin
      pick = GNT_CPU;
    end
  end

  assign gnt_valid = elig_cpu || elig_snd;
  assign gnt_snd   = (pick == GNT_SND);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GNT_SND;
    end else if (commit && gnt_valid) begin
      last_grant <= pick;
    end
  end

endmodule

// File: rtl/mcr_rom_port_arbiter.sv
// Shares one single-port 64k x 8 program RAM between the main CPU, the sound CPU
// and the HPS ROM download path.
module mcr_rom_port_arbiter
  import mcr_rom_pkg::*;
#(
  parameter int            AW       = ROM_AW,
  parameter int            DW       = ROM_DW,
  parameter logic [AW-1:0] SND_BASE = SND_ROM_BASE
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [24:0]   dl_addr,
  input  logic [DW-1:0] dl_data,
  output logic          dl_done,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_data,
  input  logic          snd_req,
  input  logic [13:0]   snd_addr,
  output logic          snd_ack,
  output logic [DW-1:0] snd_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q
);

  // Reset asserts immediately but is released on a clock edge
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  state_e        state;
  grant_e        rd_gnt;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] grant_addr;
  logic          dl_active_q;
  logic          gnt_valid;
  logic          gnt_snd;
  logic          grant_now;

  rr_arb2 u_arb (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .req_cpu   (cpu_req),
    .req_snd   (snd_req),
    .mask_cpu  (cpu_ack),
    .mask_snd  (snd_ack),
    .commit    (grant_now),
    .gnt_valid (gnt_valid),
    .gnt_snd   (gnt_snd)
  );

  // A pending download outranks any read waiting in IDLE
  assign grant_now  = rst_n && (state == IDLE) && !dl_active && gnt_valid;
  assign grant_addr = gnt_snd ? (SND_BASE | {{(AW-14){1'b0}}, snd_addr}) : cpu_addr;

  // The grant address goes out combinationally so the RAM samples it in the grant cycle
  always_comb begin
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_d    = '0;
    case (state)
      IDLE: begin
        if (grant_now) begin
          mem_addr = grant_addr;
        end
      end
      READ: begin
        mem_addr = rd_addr;
      end
      DL: begin
        mem_addr = dl_addr[AW-1:0];
        mem_d    = dl_data;
        mem_we   = dl_wr && (dl_addr[24:AW] == '0);
      end
      default: begin
        mem_addr = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_gnt      <= GNT_CPU;
      rd_addr     <= '0;
      cpu_ack     <= 1'b0;
      snd_ack     <= 1'b0;
      cpu_data    <= '0;
      snd_data    <= '0;
      dl_done     <= 1'b0;
      dl_active_q <= 1'b0;
    end else begin
      cpu_ack     <= 1'b0;
      snd_ack     <= 1'b0;
      dl_active_q <= dl_active;
      dl_done     <= dl_active_q && !dl_active;
      case (state)
        IDLE: begin
          if (dl_active) begin
            state <= DL;
          end else if (grant_now) begin
            state   <= READ;
            rd_addr <= grant_addr;
            rd_gnt  <= gnt_snd ? GNT_SND : GNT_CPU;
          end
        end
        READ: begin
          state <= IDLE;
          if (rd_gnt == GNT_CPU) begin
            cpu_ack  <= 1'b1;
            cpu_data <= mem_q;
          end else begin
            snd_ack  <= 1'b1;
            snd_data <= mem_q;
          end
        end
        DL: begin
          if (!dl_active) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcr_rom_port_arbiter.sv
// Scoreboard bench for mcr_rom_port_arbiter: random and directed reads plus ROM download.
module tb_mcr_rom_port_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        dl_active = 1'b0;
  logic        dl_wr = 1'b0;
  logic [24:0] dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic        dl_done;
  logic        cpu_req = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_data;
  logic        snd_req = 1'b0;
  logic [13:0] snd_addr = '0;
  logic        snd_ack;
  logic [7:0]  snd_data;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_d;
  logic [7:0]  mem_q = '0;

  mcr_rom_port_arbiter #(.AW(16), .DW(8), .SND_BASE(16'hC000)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .dl_active (dl_active),
    .dl_wr     (dl_wr),
    .dl_addr   (dl_addr),
    .dl_data   (dl_data),
    .dl_done   (dl_done),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_ack   (cpu_ack),
    .cpu_data  (cpu_data),
    .snd_req   (snd_req),
    .snd_addr  (snd_addr),
    .snd_ack   (snd_ack),
    .snd_data  (snd_data),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_d     (mem_d),
    .mem_q     (mem_q)
  );

  always #5 clk_sys = ~clk_sys;

  int          checks = 0;
  int          passes = 0;
  int unsigned cyc = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Background ROM contents, so every address holds a distinct-looking byte
  function automatic logic [7:0] initPat(input logic [15:0] a);
    logic [15:0] t;
    t = a * 16'd40503;
    return t[15:8] ^ a[7:0];
  endfunction

  // Synchronous single-port RAM; stores the difference from the background pattern
  bit   [7:0]  ram_delta [0:65535] = '{default: 8'h00};
  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = '0;
  logic [7:0]  poke_data = '0;

  always @(posedge clk_sys) begin
    if (mem_we) ram_delta[mem_addr] <= mem_d ^ initPat(mem_addr);
    else if (poke_en) ram_delta[poke_addr] <= poke_data ^ initPat(poke_addr);
    mem_q <= ram_delta[mem_addr] ^ initPat(mem_addr);
  end

  // Reference model: what each ROM byte should read back as
  logic [7:0] ref_mem [0:65535];
  logic [7:0] cpu_exp [$];
  logic [7:0] snd_exp [$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Fairness window bookkeeping
  bit          win_en = 1'b0;
  int unsigned win_c0 = 0;
  int          win_cpu = 0;
  int          win_snd = 0;
  logic        last_snd = 1'b1;

  // Monitor: pops the scoreboard whenever an ack is presented
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (cpu_ack) begin
        checkOutput("ack_exclusive", {31'd0, snd_ack}, 32'd0);
        if (cpu_exp.size() == 0) begin
          checks++;
          $display("[TB] FAIL cpu_ack_spurious: ack with no outstanding request (cycle %0d)", cyc);
        end else begin
          checkOutput("cpu_data", {24'd0, cpu_data}, {24'd0, cpu_exp.pop_front()});
        end
        if (win_en && (cyc - win_c0) >= 2 && (cyc - win_c0) <= 41) begin
          checkOutput("rr_alternate_cpu", {31'd0, last_snd}, 32'd1);
          last_snd = 1'b0;
          win_cpu++;
        end
      end
      if (snd_ack) begin
        if (snd_exp.size() == 0) begin
          checks++;
          $display("[TB] FAIL snd_ack_spurious: ack with no outstanding request (cycle %0d)", cyc);
        end else begin
          checkOutput("snd_data", {24'd0, snd_data}, {24'd0, snd_exp.pop_front()});
        end
        if (win_en && (cyc - win_c0) >= 2 && (cyc - win_c0) <= 41) begin
          checkOutput("rr_alternate_snd", {31'd0, last_snd}, 32'd0);
          last_snd = 1'b1;
          win_snd++;
        end
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic sampleNeg();
    @(negedge clk_sys);
  endtask

  task automatic issueCpu(input logic [15:0] a);
    cpu_addr = a;
    cpu_req  = 1'b1;
    cpu_exp.push_back(ref_mem[a]);
  endtask

  task automatic issueSnd(input logic [13:0] a);
    snd_addr = a;
    snd_req  = 1'b1;
    snd_exp.push_back(ref_mem[16'hC000 | {2'b00, a}]);
  endtask

  task automatic pokeRam(input logic [15:0] a, input logic [7:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    nextCycle();
    poke_en   = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic assertReset();
    reset_n   = 1'b0;
    cpu_req   = 1'b0;
    snd_req   = 1'b0;
    dl_active = 1'b0;
    dl_wr     = 1'b0;
    cpu_exp.delete();
    snd_exp.delete();
  endtask

  task automatic releaseReset();
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (4) @(posedge clk_sys);
    #1;
  endtask

  task automatic resetDut();
    assertReset();
    #1;
    checkOutput("reset_acks", {29'd0, cpu_ack, snd_ack, mem_we}, 32'd0);
    checkOutput("reset_outs", {dl_done, 7'd0, mem_addr, cpu_data}, 32'd0);
    releaseReset();
  endtask

  // Requester driver: drops req the cycle after its ack, optionally re-issuing at once
  logic cpu_ack_seen = 1'b0;
  logic snd_ack_seen = 1'b0;

  task automatic applyStimulus(input int n, input bit issue_cpu, input bit issue_snd, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      if (cpu_req && cpu_ack_seen) cpu_req = 1'b0;
      if (snd_req && snd_ack_seen) snd_req = 1'b0;
      if (!cpu_req && issue_cpu && ($urandom_range(99) >= gap_pct)) issueCpu(16'($urandom));
      if (!snd_req && issue_snd && ($urandom_range(99) >= gap_pct)) issueSnd(14'($urandom));
      sampleNeg();
      cpu_ack_seen = cpu_ack;
      snd_ack_seen = snd_ack;
      nextCycle();
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (cpu_req || snd_req); i++) applyStimulus(1, 1'b0, 1'b0, 0);
    checkOutput("drain_done", {30'd0, cpu_req, snd_req}, 32'd0);
  endtask

  // Uncontended read: ack must come exactly two cycles after the request
  task automatic readCpu(input logic [15:0] a);
    int lat;
    lat = -1;
    issueCpu(a);
    for (int i = 0; i < 12; i++) begin
      sampleNeg();
      if (cpu_ack) begin
        lat = i;
        break;
      end
      nextCycle();
    end
    if (lat >= 0) nextCycle();
    cpu_req = 1'b0;
    checkOutput("read_latency", lat, 32'd2);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = initPat(16'(i));
    resetDut();

    $display("[TB] single cpu read");
    pokeRam(16'h1234, 8'h5A);
    issueCpu(16'h1234);
    sampleNeg();
    checkOutput("t1_addr_c0", mem_addr, 32'h1234);
    checkOutput("t1_ack_c0", {31'd0, cpu_ack}, 32'd0);
    nextCycle(); sampleNeg();
    checkOutput("t1_addr_c1", mem_addr, 32'h1234);
    checkOutput("t1_ack_c1", {31'd0, cpu_ack}, 32'd0);
    nextCycle(); sampleNeg();
    checkOutput("t1_ack_c2", {31'd0, cpu_ack}, 32'd1);
    checkOutput("t1_data_c2", {24'd0, cpu_data}, 32'h5A);
    nextCycle();
    cpu_req = 1'b0;
    sampleNeg();
    checkOutput("t1_ack_c3", {31'd0, cpu_ack}, 32'd0);
    checkOutput("t1_data_held", {24'd0, cpu_data}, 32'h5A);
    nextCycle();

    $display("[TB] simultaneous cpu and snd");
    resetDut();
    pokeRam(16'hC123, 8'hA7);
    issueCpu(16'h0042);
    issueSnd(14'h0123);
    sampleNeg();
    checkOutput("t2_addr_c0", mem_addr, 32'h0042);
    nextCycle(); nextCycle(); sampleNeg();
    checkOutput("t2_cpu_ack_c2", {31'd0, cpu_ack}, 32'd1);
    checkOutput("t2_snd_ack_c2", {31'd0, snd_ack}, 32'd0);
    checkOutput("t2_snd_addr_c2", mem_addr, 32'hC123);
    nextCycle();
    cpu_req = 1'b0;
    sampleNeg();
    checkOutput("t2_snd_addr_c3", mem_addr, 32'hC123);
    checkOutput("t2_acks_c3", {30'd0, cpu_ack, snd_ack}, 32'd0);
    nextCycle(); sampleNeg();
    checkOutput("t2_snd_ack_c4", {31'd0, snd_ack}, 32'd1);
    checkOutput("t2_snd_data_c4", {24'd0, snd_data}, 32'hA7);
    nextCycle();
    snd_req = 1'b0;
    sampleNeg();
    checkOutput("t2_snd_ack_c5", {31'd0, snd_ack}, 32'd0);
    nextCycle();

    $display("[TB] sustained load fairness");
    resetDut();
    cpu_ack_seen = 1'b0;
    snd_ack_seen = 1'b0;
    win_cpu  = 0;
    win_snd  = 0;
    last_snd = 1'b1;
    win_c0   = cyc;
    win_en   = 1'b1;
    applyStimulus(40, 1'b1, 1'b1, 0);
    drain();
    win_en = 1'b0;
    checkOutput("t3_cpu_acks", win_cpu, 32'd10);
    checkOutput("t3_snd_acks", win_snd, 32'd10);

    $display("[TB] random traffic");
    resetDut();
    cpu_ack_seen = 1'b0;
    snd_ack_seen = 1'b0;
    applyStimulus(300, 1'b1, 1'b1, 40);
    drain();
    repeat (3) nextCycle();
    checkOutput("rand_queues_empty", cpu_exp.size() + snd_exp.size(), 32'd0);

    $display("[TB] download during read");
    resetDut();
    issueCpu(16'h0777);
    nextCycle();
    dl_active = 1'b1;
    issueSnd(14'h0200);
    nextCycle(); sampleNeg();
    checkOutput("t4_cpu_ack", {31'd0, cpu_ack}, 32'd1);
    checkOutput("t4_no_grant", mem_addr, 32'h0000);
    checkOutput("t4_we_idle", {31'd0, mem_we}, 32'd0);
    nextCycle();
    cpu_req = 1'b0;
    dl_wr   = 1'b1;
    dl_addr = 25'h000_0010;
    dl_data = 8'h3C;
    ref_mem[16'h0010] = 8'h3C;
    sampleNeg();
    checkOutput("t4_we_in_range", {31'd0, mem_we}, 32'd1);
    checkOutput("t4_dl_addr", mem_addr, 32'h0010);
    checkOutput("t4_dl_data", {24'd0, mem_d}, 32'h3C);
    nextCycle();
    dl_addr = 25'h1_0005;
    dl_data = 8'h99;
    sampleNeg();
    checkOutput("t4_we_out_of_range", {31'd0, mem_we}, 32'd0);
    nextCycle();
    dl_wr     = 1'b0;
    dl_active = 1'b0;
    sampleNeg();
    checkOutput("t4_done_early", {31'd0, dl_done}, 32'd0);
    nextCycle(); sampleNeg();
    checkOutput("t4_done_pulse", {31'd0, dl_done}, 32'd1);
    checkOutput("t4_snd_grant_addr", mem_addr, 32'hC200);
    nextCycle(); sampleNeg();
    checkOutput("t4_done_once", {31'd0, dl_done}, 32'd0);
    nextCycle(); sampleNeg();
    checkOutput("t4_snd_ack", {31'd0, snd_ack}, 32'd1);
    nextCycle();
    snd_req = 1'b0;
    readCpu(16'h0010);
    readCpu(16'h0005);

    $display("[TB] request pending across download");
    resetDut();
    dl_active = 1'b1;
    nextCycle(); nextCycle();
    issueSnd(14'h3ABC);
    for (int i = 0; i < 4; i++) begin
      sampleNeg();
      checkOutput("t5_held_in_dl", {30'd0, snd_ack, mem_we}, 32'd0);
      nextCycle();
    end
    dl_active = 1'b0;
    sampleNeg();
    checkOutput("t5_done_early", {31'd0, dl_done}, 32'd0);
    nextCycle(); sampleNeg();
    checkOutput("t5_done_pulse", {31'd0, dl_done}, 32'd1);
    checkOutput("t5_grant_addr", mem_addr, 32'hFABC);
    nextCycle(); sampleNeg();
    checkOutput("t5_done_once", {31'd0, dl_done}, 32'd0);
    checkOutput("t5_ack_early", {31'd0, snd_ack}, 32'd0);
    nextCycle(); sampleNeg();
    checkOutput("t5_snd_ack", {31'd0, snd_ack}, 32'd1);
    nextCycle();
    snd_req = 1'b0;
    sampleNeg();
    checkOutput("t5_ack_gone", {31'd0, snd_ack}, 32'd0);
    nextCycle();

    $display("[TB] reset during read");
    resetDut();
    issueCpu(16'h1234);
    nextCycle();
    #1;
    checkOutput("t6_read_addr", mem_addr, 32'h1234);
    assertReset();
    #1;
    checkOutput("t6_async_addr", mem_addr, 32'h0000);
    checkOutput("t6_async_ack", {31'd0, cpu_ack}, 32'd0);
    releaseReset();
    for (int i = 0; i < 6; i++) begin
      sampleNeg();
      checkOutput("t6_no_ack", {30'd0, cpu_ack, snd_ack}, 32'd0);
      nextCycle();
    end
    readCpu(16'h4321);

    issueCpu(16'h2222);
    nextCycle(); nextCycle();
    #1;
    checkOutput("t6_ack_before", {31'd0, cpu_ack}, 32'd1);
    assertReset();
    #1;
    checkOutput("t6_ack_async", {31'd0, cpu_ack}, 32'd0);
    checkOutput("t6_data_async", {24'd0, cpu_data}, 32'd0);
    releaseReset();

    dl_active = 1'b1;
    nextCycle();
    dl_wr   = 1'b1;
    dl_addr = 25'h000_0020;
    dl_data = 8'hE1;
    ref_mem[16'h0020] = 8'hE1;
    #1;
    checkOutput("t6_we_before", {31'd0, mem_we}, 32'd1);
    nextCycle();
    dl_wr     = 1'b0;
    dl_active = 1'b0;
    nextCycle();
    #1;
    checkOutput("t6_done_before", {31'd0, dl_done}, 32'd1);
    assertReset();
    #1;
    checkOutput("t6_done_async", {31'd0, dl_done}, 32'd0);
    releaseReset();
    readCpu(16'h0020);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
